// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcodes, jump conditions, CMP bit offsets (bit = WIDTH - offset) and FSM states.
package alu_mc_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_OR, OP_LOAD, OP_CMP, OP_SHL, OP_JUMP,
    OP_SUB, OP_AND, OP_XOR, OP_SHR, OP_MUL, OP_DIV
  } op_t;
  typedef enum logic [2:0] {J_EQ, J_AZ, J_BZ, J_NAZ, J_NBZ, J_AGB, J_ALB, J_NEVER} jcond_t;
  localparam int CMP_EQ  = 2;
  localparam int CMP_AZ  = 3;
  localparam int CMP_BZ  = 4;
  localparam int CMP_AGB = 5;
  localparam int CMP_ALB = 6;
  typedef enum logic {S_IDLE, S_ITER} state_t;
endpackage

// File: rtl/alu_mc_muldiv.sv
// alu_mc_muldiv: iterative shift-add multiplier and restoring divider, one step per cycle.
// Divider datapath exists only when ALU_MC_DIV_EN is defined.
module alu_mc_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             last,
  input  logic             abort,
  input  logic             div,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);
  logic [WIDTH-1:0] x, y, z, x_n, y_n, z_n, ma, mb, val;
  logic neg, is_div, dv;
  assign ma = (sgn && a[WIDTH-1]) ? -a : a;
  assign mb = (sgn && b[WIDTH-1]) ? -b : b;
`ifdef ALU_MC_DIV_EN
  logic [WIDTH:0] r, diff;
  assign dv = div;
  assign r = {x, z[WIDTH-1]};
  assign diff = r - {1'b0, y};
`else
  logic unused_div;
  assign dv = 1'b0;
  assign unused_div = div;
`endif
  // x: accumulator/remainder, y: multiplicand/divisor, z: multiplier/quotient
  always_comb begin
    x_n = x + (z[0] ? y : '0);
    y_n = y << 1;
    z_n = z >> 1;
`ifdef ALU_MC_DIV_EN
    if (is_div) begin
      x_n = diff[WIDTH] ? r[WIDTH-1:0] : diff[WIDTH-1:0];
      y_n = y;
      z_n = {z[WIDTH-2:0], ~diff[WIDTH]};
    end
`endif
  end
  assign val = is_div ? z_n : x_n;
  assign res = neg ? -val : val;
  assign done = step && last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x <= '0;
      y <= '0;
      z <= '0;
      neg <= 1'b0;
      is_div <= 1'b0;
    end else if (abort) begin
      x <= '0;
      y <= '0;
      z <= '0;
      neg <= 1'b0;
      is_div <= 1'b0;
    end else if (start) begin
      x <= '0;
      y <= dv ? mb : ma;
      z <= dv ? ma : mb;
      neg <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      is_div <= dv;
    end else if (step) begin
      x <= x_n;
      y <= y_n;
      z <= z_n;
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready issue; single-cycle ops plus iterative MUL/DIV.
// ALU_MC_DIV_EN enables the iterative divider; otherwise DIV returns 0 with flag_cv set.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IMM_W = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_imm,
  input  logic             data_d_we,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_result,
  output logic             data_write_reg,
  output logic             should_branch,
  output logic             flag_cv
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_VAL = WIDTH;
  logic [3:0] op;
  logic v, cv_c, br_c, eq, az, bz, gt, lt, iter_op, md_done, pend_we, unused_imm;
  logic [WIDTH:0] add_s, sub_s;
  logic [WIDTH-1:0] sra, res_c, md_res;
  logic [CNT_W-1:0] cnt;
  state_t state;
  assign op = alu_op[4:1];
  assign v = alu_op[0];
  assign in_ready = state == S_IDLE;
  assign add_s = v ? {data_a[WIDTH-1], data_a} + {data_b[WIDTH-1], data_b} : {1'b0, data_a} + {1'b0, data_b};
  assign sub_s = v ? {data_a[WIDTH-1], data_a} - {data_b[WIDTH-1], data_b} : {1'b0, data_a} - {1'b0, data_b};
  assign eq = data_a == data_b;
  assign az = data_a == '0;
  assign bz = data_b == '0;
  assign gt = v ? $signed(data_a) > $signed(data_b) : data_a > data_b;
  assign lt = v ? $signed(data_a) < $signed(data_b) : data_a < data_b;
  assign sra = $signed(data_a) >>> data_b;
  assign unused_imm = ^data_imm[WIDTH-1:IMM_W];
`ifdef ALU_MC_DIV_EN
  assign iter_op = op == OP_MUL || (op == OP_DIV && !bz);
`else
  assign iter_op = op == OP_MUL;
`endif
  always_comb begin
    res_c = '0;
    cv_c = 1'b0;
    br_c = 1'b0;
    case (op)
      OP_ADD: begin
        res_c = add_s[WIDTH-1:0];
        cv_c = v ? add_s[WIDTH] ^ add_s[WIDTH-1] : add_s[WIDTH];
      end
      OP_SUB: begin
        res_c = sub_s[WIDTH-1:0];
        cv_c = v ? sub_s[WIDTH] ^ sub_s[WIDTH-1] : sub_s[WIDTH];
      end
      OP_OR:   res_c = data_a | data_b;
      OP_AND:  res_c = data_a & data_b;
      OP_XOR:  res_c = data_a ^ data_b;
      OP_LOAD: res_c = v ? WIDTH'(data_imm[IMM_W-1:0]) : {data_imm[IMM_W-1:0], {(WIDTH-IMM_W){1'b0}}};
      OP_CMP: begin
        res_c[WIDTH-CMP_EQ] = eq;
        res_c[WIDTH-CMP_AZ] = az;
        res_c[WIDTH-CMP_BZ] = bz;
        res_c[WIDTH-CMP_AGB] = gt;
        res_c[WIDTH-CMP_ALB] = lt;
      end
      OP_SHL: res_c = data_b < W_VAL ? data_a << data_b : data_a;
      OP_SHR: res_c = data_b < W_VAL ? (v ? sra : data_a >> data_b) : data_a;
      // data_a is expected to carry a previous CMP result
      OP_JUMP: begin
        res_c = data_b;
        case (jcond_t'({v, data_imm[1:0]}))
          J_EQ:    br_c = data_a[WIDTH-CMP_EQ];
          J_AZ:    br_c = data_a[WIDTH-CMP_AZ];
          J_BZ:    br_c = data_a[WIDTH-CMP_BZ];
          J_NAZ:   br_c = !data_a[WIDTH-CMP_AZ];
          J_NBZ:   br_c = !data_a[WIDTH-CMP_BZ];
          J_AGB:   br_c = data_a[WIDTH-CMP_AGB];
          J_ALB:   br_c = data_a[WIDTH-CMP_ALB];
          default: br_c = 1'b0;
        endcase
      end
`ifdef ALU_MC_DIV_EN
      OP_DIV: res_c = '1;
`else
      OP_DIV: cv_c = 1'b1;
`endif
      default: res_c = '0;
    endcase
  end
  alu_mc_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk(clk),
    .rst_n(rst_n),
    .start(in_valid && in_ready && iter_op),
    .step(state == S_ITER && !abort),
    .last(cnt == '0),
    .abort(state == S_ITER && abort),
    .div(op == OP_DIV),
    .sgn(v),
    .a(data_a),
    .b(data_b),
    .done(md_done),
    .res(md_res)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      pend_we <= 1'b0;
      out_valid <= 1'b0;
      data_result <= '0;
      data_write_reg <= 1'b0;
      should_branch <= 1'b0;
      flag_cv <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == S_IDLE) begin
        if (in_valid && iter_op) begin
          state <= S_ITER;
          cnt <= CNT_W'(WIDTH - 1);
          pend_we <= data_d_we;
        end else if (in_valid) begin
          out_valid <= 1'b1;
          data_result <= res_c;
          flag_cv <= cv_c;
          should_branch <= br_c;
          data_write_reg <= data_d_we;
        end
      end else if (abort) begin
        state <= S_IDLE;
        cnt <= '0;
      end else if (md_done) begin
        state <= S_IDLE;
        out_valid <= 1'b1;
        data_result <= md_res;
        flag_cv <= 1'b0;
        should_branch <= 1'b0;
        data_write_reg <= pend_we;
      end else
        cnt <= cnt - 1'b1;
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized self-checking bench for alu_mc at WIDTH=16 and 32 against a behavioural model.
module tb_alu_mc;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, abort = 1'b0, d_we = 1'b0;
  logic [4:0] alu_op = '0;
  logic [15:0] a = '0, b = '0, imm = '0;
  logic in_ready, out_valid, write_reg, branch, cv;
  logic [15:0] result;
  logic v32 = 1'b0, ab32 = 1'b0, we32 = 1'b0;
  logic [4:0] op32 = '0;
  logic [31:0] a32 = '0, b32 = '0, imm32 = '0;
  logic rdy32, ov32, wr32, br32, cv32;
  logic [31:0] res32;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .abort(abort),
    .alu_op(alu_op), .data_a(a), .data_b(b), .data_imm(imm), .data_d_we(d_we),
    .out_valid(out_valid), .data_result(result), .data_write_reg(write_reg),
    .should_branch(branch), .flag_cv(cv)
  );
  alu_mc #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .abort(ab32),
    .alu_op(op32), .data_a(a32), .data_b(b32), .data_imm(imm32), .data_d_we(we32),
    .out_valid(ov32), .data_result(res32), .data_write_reg(wr32),
    .should_branch(br32), .flag_cv(cv32)
  );

  // Reference model: {result, flag_cv, should_branch} for a single completed op at WIDTH=16
  function automatic logic [17:0] model(input logic [3:0] op, input logic vv, input logic [15:0] x, y, im);
    longint sa, sb, ua, ub, s;
    logic [15:0] r;
    logic c, br;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    ua = longint'(x);
    ub = longint'(y);
    r = '0; c = 1'b0; br = 1'b0; s = 0;
    case (op)
      4'd0, 4'd6: begin
        s = vv ? (op == 4'd0 ? sa + sb : sa - sb) : (op == 4'd0 ? ua + ub : ua - ub);
        r = s[15:0];
        c = vv ? (s != longint'($signed(s[15:0]))) : (op == 4'd0 ? s > 65535 : ua < ub);
      end
      4'd1: r = x | y;
      4'd2: r = vv ? {8'h00, im[7:0]} : {im[7:0], 8'h00};
      4'd3: begin
        r[14] = x == y;
        r[13] = x == 0;
        r[12] = y == 0;
        r[11] = vv ? sa > sb : ua > ub;
        r[10] = vv ? sa < sb : ua < ub;
      end
      4'd4: r = ub < 16 ? 16'(ua << ub) : x;
      4'd5: begin
        r = y;
        case ({vv, im[1:0]})
          3'd0: br = x[14];
          3'd1: br = x[13];
          3'd2: br = x[12];
          3'd3: br = !x[13];
          3'd4: br = !x[12];
          3'd5: br = x[11];
          3'd6: br = x[10];
          default: br = 1'b0;
        endcase
      end
      4'd7: r = x & y;
      4'd8: r = x ^ y;
      4'd9: r = ub < 16 ? (vv ? 16'(sa >>> ub) : 16'(ua >> ub)) : x;
      4'd10: begin
        s = vv ? sa * sb : ua * ub;
        r = s[15:0];
      end
      4'd11: begin
`ifdef ALU_MC_DIV_EN
        r = y == 0 ? 16'hFFFF : (vv ? 16'(sa / sb) : 16'(ua / ub));
`else
        c = 1'b1;
`endif
      end
      default: r = '0;
    endcase
    return {r, c, br};
  endfunction

  function automatic bit is_iter(input logic [3:0] op, input logic [15:0] y);
`ifdef ALU_MC_DIV_EN
    return op == 4'd10 || (op == 4'd11 && y != 0);
`else
    return op == 4'd10;
`endif
  endfunction

  task automatic issue(input logic [3:0] op, input logic vv, input logic [15:0] x, y, im, input logic we);
    @(negedge clk);
    alu_op = {op, vv}; a = x; b = y; imm = im; d_we = we; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic issue32(input logic [3:0] op, input logic vv, input logic [31:0] x, y, input logic we);
    @(negedge clk);
    op32 = {op, vv}; a32 = x; b32 = y; we32 = we; v32 = 1'b1;
    @(posedge clk);
    #1 v32 = 1'b0;
  endtask

  // Returns cycles from accept to out_valid (capped) and how many of those cycles had in_ready high
  task automatic wait_done(output int lat, output int hi);
    lat = 1; hi = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) hi++;
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    tests++;
    if ({out_valid, result, write_reg, branch, cv} !== 20'h0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset16: ov=%b res=%h wr=%b br=%b cv=%b rdy=%b, want all 0 and rdy=1", out_valid, result, write_reg, branch, cv, in_ready);
    end
    tests++;
    if ({ov32, res32, wr32, br32, cv32} !== 36'h0 || rdy32 !== 1'b1) begin
      fails++;
      $display("FAIL reset32: ov=%b res=%h rdy=%b, want 0/0/1", ov32, res32, rdy32);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {logic [3:0] op; logic vv; logic [15:0] x, y, im, r; logic c, br; string nm;} vec_t;

  task automatic test_directed;
    vec_t t[$];
    t.push_back('{4'd0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, "add_carry"});
    t.push_back('{4'd3, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'h0400, 1'b0, 1'b0, "cmp_signed"});
    t.push_back('{4'd5, 1'b1, 16'h0800, 16'h1234, 16'h0001, 16'h1234, 1'b0, 1'b1, "jump_agb"});
    t.push_back('{4'd5, 1'b1, 16'hFFFF, 16'h1234, 16'h0003, 16'h1234, 1'b0, 1'b0, "jump_never"});
    t.push_back('{4'd2, 1'b0, 16'h0000, 16'h0000, 16'h00A5, 16'hA500, 1'b0, 1'b0, "load_high"});
    t.push_back('{4'd9, 1'b1, 16'h8000, 16'h0010, 16'h0000, 16'h8000, 1'b0, 1'b0, "shr_oversize"});
    t.push_back('{4'd6, 1'b1, 16'h8000, 16'h0001, 16'h0000, 16'h7FFF, 1'b1, 1'b0, "sub_overflow"});
`ifdef ALU_MC_DIV_EN
    t.push_back('{4'd11, 1'b1, 16'h0005, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, "div_by_zero"});
`else
    t.push_back('{4'd11, 1'b1, 16'hFFF9, 16'h0002, 16'h0000, 16'h0000, 1'b1, 1'b0, "div_disabled"});
`endif
    foreach (t[i]) begin
      issue(t[i].op, t[i].vv, t[i].x, t[i].y, t[i].im, 1'b1);
      tests++;
      if ({out_valid, result, cv, branch, write_reg} !== {1'b1, t[i].r, t[i].c, t[i].br, 1'b1}) begin
        fails++;
        $display("FAIL %s: ov=%b res=%h cv=%b br=%b wr=%b, want ov=1 res=%h cv=%b br=%b wr=1",
                 t[i].nm, out_valid, result, cv, branch, write_reg, t[i].r, t[i].c, t[i].br);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] op;
    logic vv, we;
    logic [15:0] x, y, im;
    logic [17:0] e;
    for (int i = 0; i < 200; i++) begin
      do op = 4'($urandom_range(0, 15)); while (op == 4'd10);
      vv = 1'($urandom);
      we = 1'($urandom);
      x = 16'($urandom);
      y = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 20)) : 16'($urandom);
      if ($urandom_range(0, 7) == 0) y = x;
      if (op == 4'd5 || op == 4'd2) im = 16'($urandom); else im = '0;
`ifdef ALU_MC_DIV_EN
      if (op == 4'd11) y = '0;
`endif
      e = model(op, vv, x, y, im);
      issue(op, vv, x, y, im, we);
      tests++;
      if ({out_valid, result, cv, branch, write_reg} !== {1'b1, e, we}) begin
        fails++;
        $display("FAIL rand op=%0d v=%b a=%h b=%h imm=%h: ov=%b res=%h cv=%b br=%b wr=%b, want res=%h cv=%b br=%b wr=%b",
                 op, vv, x, y, im, out_valid, result, cv, branch, write_reg, e[17:2], e[1], e[0], we);
      end
    end
  endtask

  task automatic test_mul_hold;
    int lat, hi;
    @(negedge clk);
    alu_op = {4'd10, 1'b1}; a = 16'hFFFD; b = 16'h0007; d_we = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    alu_op = {4'd0, 1'b0}; a = 16'h0003; b = 16'h0004; d_we = 1'b0;
    wait_done(lat, hi);
    tests++;
    if (lat != 17 || hi != 0 || result !== 16'hFFEB || write_reg !== 1'b1 || cv !== 1'b0) begin
      fails++;
      $display("FAIL mul_signed: lat=%0d rdy_hi=%0d res=%h wr=%b cv=%b, want lat=17 rdy_hi=0 res=ffeb wr=1 cv=0", lat, hi, result, write_reg, cv);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || result !== 16'h0007 || write_reg !== 1'b0) begin
      fails++;
      $display("FAIL held_add: ov=%b res=%h wr=%b, want ov=1 res=0007 wr=0", out_valid, result, write_reg);
    end
  endtask

  task automatic test_iter_random;
    int lat, hi;
    logic [3:0] op;
    logic vv;
    logic [15:0] x, y;
    logic [17:0] e;
`ifdef ALU_MC_DIV_EN
    issue(4'd11, 1'b1, 16'hFFF9, 16'h0002, 16'h0, 1'b1);
    wait_done(lat, hi);
    tests++;
    if (lat != 17 || hi != 0 || result !== 16'hFFFD) begin
      fails++;
      $display("FAIL div_signed: lat=%0d rdy_hi=%0d res=%h, want lat=17 rdy_hi=0 res=fffd", lat, hi, result);
    end
`endif
    for (int i = 0; i < 12; i++) begin
      op = 4'($urandom_range(10, 11));
      vv = 1'($urandom);
      x = 16'($urandom);
      y = $urandom_range(0, 1) ? 16'($urandom_range(1, 300)) : 16'($urandom_range(1, 65535));
      if (!is_iter(op, y)) op = 4'd10;
      e = model(op, vv, x, y, 16'h0);
      issue(op, vv, x, y, 16'h0, 1'b1);
      wait_done(lat, hi);
      tests++;
      if (lat != 17 || hi != 0 || {result, cv, branch, write_reg} !== {e, 1'b1}) begin
        fails++;
        $display("FAIL iter op=%0d v=%b a=%h b=%h: lat=%0d rdy_hi=%0d res=%h cv=%b, want lat=17 rdy_hi=0 res=%h cv=%b",
                 op, vv, x, y, lat, hi, result, cv, e[17:2], e[1]);
      end
    end
  endtask

  task automatic test_abort;
    int seen;
    issue(4'd10, 1'b0, 16'h1234, 16'h0055, 16'h0, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_iter: ov=%b rdy=%b, want ov=0 rdy=1", out_valid, in_ready);
    end
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL abort_no_pulse: %0d out_valid pulses, want 0", seen);
    end
    @(negedge clk) abort = 1'b1;
    issue(4'd8, 1'b0, 16'h00F0, 16'h0FF0, 16'h0, 1'b0);
    abort = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || result !== 16'h0F00) begin
      fails++;
      $display("FAIL abort_idle: ov=%b res=%h, want ov=1 res=0f00", out_valid, result);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    issue(4'd0, 1'b0, 16'hFFFF, 16'h0003, 16'h0, 1'b1);
`ifdef ALU_MC_DIV_EN
    issue(4'd11, 1'b0, 16'h7777, 16'h0003, 16'h0, 1'b1);
`else
    issue(4'd10, 1'b0, 16'h7777, 16'h0003, 16'h0, 1'b1);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, result, write_reg, branch, cv} !== 20'h0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid: ov=%b res=%h wr=%b br=%b cv=%b rdy=%b, want all 0 and rdy=1", out_valid, result, write_reg, branch, cv, in_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    tests++;
    if (seen != 0 || result !== 16'h0000) begin
      fails++;
      $display("FAIL reset_discard: %0d pulses res=%h, want 0 pulses res=0000", seen, result);
    end
  endtask

  task automatic test_add32;
    logic vv;
    logic [31:0] x, y;
    longint s;
    logic c;
    issue32(4'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    tests++;
    if ({ov32, res32, cv32, wr32} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL add32_carry: ov=%b res=%h cv=%b wr=%b, want ov=1 res=0 cv=1 wr=1", ov32, res32, cv32, wr32);
    end
    for (int i = 0; i < 12; i++) begin
      vv = 1'($urandom);
      x = $urandom;
      y = $urandom;
      s = vv ? longint'($signed(x)) + longint'($signed(y)) : longint'(x) + longint'(y);
      c = vv ? (s != longint'($signed(s[31:0]))) : s[32];
      issue32(4'd0, vv, x, y, 1'b0);
      tests++;
      if ({ov32, res32, cv32, br32} !== {1'b1, s[31:0], c, 1'b0}) begin
        fails++;
        $display("FAIL add32 v=%b a=%h b=%h: res=%h cv=%b, want res=%h cv=%b", vv, x, y, res32, cv32, s[31:0], c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_mul_hold();
    test_iter_random();
    test_abort();
    test_reset_mid();
    test_add32();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
